fetch_queue_unit: RTL and testbench

//  Parametrised IF stage for the TP4 pipeline. Drives a synchronous instruction memory
//  (1-cycle read latency) and buffers fetched words in a DEPTH-entry prefetch FIFO.

---
 rtl/fetch_queue_unit_pkg.sv | 18 +
 rtl/fetch_queue_unit_if.sv | 30 +++
 rtl/fetch_queue_unit_fifo.sv | 62 ++++++
 rtl/fetch_queue_unit.sv | 130 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared types, defaults and helpers for the fetch queue unit
package fetch_queue_unit_pkg;

    localparam int FETCH_AW    = 32;
    localparam int FETCH_DW    = 32;
    localparam int FETCH_DEPTH = 4;
    localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_DW-1:0] instr;
        logic [FETCH_AW-1:0] pc_next;
    } fetch_entry_t;

    function automatic logic [FETCH_AW-1:0] next_pc(input logic [FETCH_AW-1:0] pc);
        return pc + FETCH_AW'(1);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction memory bus and ID hand-off bundle
interface fetch_queue_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          imem_en;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [DW-1:0] imem_rdata;

    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] id_instr;
    logic [AW-1:0] id_pc_next;

    modport master (
        output imem_en, imem_we, imem_addr, imem_wdata,
        input  imem_rdata,
        output id_valid, id_instr, id_pc_next,
        input  id_ready
    );

    modport slave (
        input  imem_en, imem_we, imem_addr, imem_wdata,
        output imem_rdata,
        input  id_valid, id_instr, id_pc_next,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// rtl/fetch_queue_unit_fifo.sv - circular prefetch buffer with push/pop/flush and occupancy count
module fetch_queue_unit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - IF stage: issues imem reads, buffers words, hands {instr, pc+1} to ID
// FETCH_BYPASS_EN: present a response straight to ID when the prefetch buffer is empty
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            DW       = FETCH_DW,
    parameter int            DEPTH    = FETCH_DEPTH,
    parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [AW-1:0]        redirect_pc,
    input  logic                 stop_debug,
    input  logic                 load_program,
    input  logic [AW-1:0]        load_addr,
    input  logic [DW-1:0]        load_data,
    input  logic                 load_we,
    fetch_queue_unit_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc_next;
    } entry_t;

    function automatic logic [AW-1:0] inc_pc(input logic [AW-1:0] a);
        return a + AW'(1);
    endfunction

    logic [AW-1:0] pc;
    logic [AW-1:0] tag;
    logic          inflight;
    logic [AW-1:0] fetch_addr;
    logic [SW-1:0] credit_used;
    logic          issue;
    logic          flush;
    logic          resp_live;
    logic          bypass_sel;
    logic          handshake;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    entry_t        push_entry;
    entry_t        head_entry;
    logic [$bits(entry_t)-1:0] head_bits;

    assign flush      = redirect_valid || load_program;
    assign fetch_addr = redirect_valid ? redirect_pc : pc;

    // Queued words plus the one in flight must never exceed the buffer, so no response is dropped.
    assign credit_used = {1'b0, count} + SW'(inflight);
    assign issue = !rst && !load_program && !stop_debug &&
                   (redirect_valid || (credit_used < SW'(DEPTH)));

    // A response returning in a redirect or load cycle belongs to the abandoned stream.
    assign resp_live = inflight && !flush;

`ifdef FETCH_BYPASS_EN
    assign bypass_sel = resp_live && empty;
`else
    assign bypass_sel = 1'b0;
`endif

    assign bus.imem_en    = issue;
    assign bus.imem_we    = load_program && load_we;
    assign bus.imem_addr  = load_program ? load_addr : fetch_addr;
    assign bus.imem_wdata = load_data;

    assign bus.id_valid = !stop_debug && !flush && (!empty || bypass_sel);
    assign handshake    = bus.id_valid && bus.id_ready;

    assign head_entry = entry_t'(head_bits);

    always_comb begin
        bus.id_instr   = head_entry.instr;
        bus.id_pc_next = head_entry.pc_next;
`ifdef FETCH_BYPASS_EN
        if (bypass_sel) begin
            bus.id_instr   = bus.imem_rdata;
            bus.id_pc_next = tag;
        end
`endif
    end

    assign push_entry = '{instr: bus.imem_rdata, pc_next: tag};
    assign push       = resp_live && !(bypass_sel && handshake);
    assign pop        = handshake && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (load_program) begin
                pc <= RESET_PC;
            end else if (issue) begin
                pc  <= inc_pc(fetch_addr);
                tag <= inc_pc(fetch_addr);
            end else if (redirect_valid) begin
                pc <= redirect_pc;
            end
        end
    end

    fetch_queue_unit_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_bits),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stop_debug;
    logic        load_program;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_we;
    logic [31:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    fetch_queue_unit_if #(.AW(32), .DW(32)) bus ();

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stop_debug     (stop_debug),
        .load_program   (load_program),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_we        (load_we),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_we && bus.imem_addr < 32'd256) mem[bus.imem_addr[7:0]] <= bus.imem_wdata;
        if (bus.imem_en) bus.imem_rdata <= (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:0]]
                                                                      : (bus.imem_addr ^ 32'h5A5A_5A5A);
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (a < 32'd256) return 32'h1000_0000 + a;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic ready);
        rst = 1'b1; redirect_valid = 0; redirect_pc = 0; stop_debug = 0;
        load_program = 0; load_addr = 0; load_data = 0; load_we = 0; bus.id_ready = ready;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 0; redirect_pc = 0; stop_debug = 0;
        load_program = 0; load_addr = 0; load_data = 0; load_we = 0; bus.id_ready = 1'b1;
        to_neg();
        n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL reset_imem_en got %b want 0", bus.imem_en); end
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
        n_cmp++; if (bus.id_instr !== 32'h0) begin n_bad++; $display("FAIL reset_id_instr got %h want 0", bus.id_instr); end
        n_cmp++; if (bus.id_pc_next !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc_next got %h want 0", bus.id_pc_next); end
        to_pos();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        reset_dut(1'b1);
        for (int c = 0; c < 8; c++) begin
            to_neg();
            if (c < 3) begin
                n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'(c)) begin
                    n_bad++; $display("FAIL stream_issue c=%0d got en=%b addr=%h want en=1 addr=%h", c, bus.imem_en, bus.imem_addr, c);
                end
            end
            if (c < LAT) begin
                n_cmp++; if (bus.id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid c=%0d got %b want 0", c, bus.id_valid); end
            end else begin
                n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== 32'(c - LAT + 1) || bus.id_instr !== exp_instr(32'(c - LAT))) begin
                    n_bad++; $display("FAIL stream_word c=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", c, bus.id_valid,
                                      bus.id_pc_next, bus.id_instr, c - LAT + 1, exp_instr(32'(c - LAT)));
                end
            end
            to_pos();
        end
        // asynchronous reset mid-stream clears outputs before any edge
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.id_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
            n_bad++; $display("FAIL async_reset got v=%b en=%b want 0 0", bus.id_valid, bus.imem_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_backpressure();
        int issues;
        reset_dut(1'b0);
        issues = 0;
        for (int c = 0; c < 10; c++) begin
            to_neg();
            if (bus.imem_en) issues++;
            to_pos();
        end
        to_neg();
        n_cmp++; if (issues !== 4) begin n_bad++; $display("FAIL bp_issue_count got %0d want 4", issues); end
        n_cmp++; if (bus.imem_en !== 1'b0 || bus.id_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_full got en=%b v=%b want en=0 v=1", bus.imem_en, bus.id_valid);
        end
        to_pos();
        bus.id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            to_neg();
            n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== 32'(k + 1) || bus.id_instr !== exp_instr(32'(k))) begin
                n_bad++; $display("FAIL bp_drain k=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, bus.id_valid,
                                  bus.id_pc_next, bus.id_instr, k + 1, exp_instr(32'(k)));
            end
            to_pos();
        end
    endtask

    task automatic test_redirect();
        bit got;
        reset_dut(1'b0);
        repeat (4) begin to_neg(); to_pos(); end
        redirect_valid = 1'b1; redirect_pc = 32'h40; bus.id_ready = 1'b1;
        to_neg();
        n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h40 || bus.id_valid !== 1'b0) begin
            n_bad++; $display("FAIL redirect_issue got en=%b addr=%h v=%b want 1 40 0", bus.imem_en, bus.imem_addr, bus.id_valid);
        end
        to_pos();
        redirect_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            to_neg();
            if (bus.id_valid) got = 1; else to_pos();
        end
        n_cmp++; if (!got || bus.id_pc_next !== 32'h41 || bus.id_instr !== exp_instr(32'h40)) begin
            n_bad++; $display("FAIL redirect_first got seen=%b pc=%h ins=%h want pc=41 ins=%h", got, bus.id_pc_next, bus.id_instr, exp_instr(32'h40));
        end
        to_pos();
        for (int j = 1; j < 3; j++) begin
            to_neg();
            n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== 32'(32'h41 + j)) begin
                n_bad++; $display("FAIL redirect_next j=%0d got v=%b pc=%h want v=1 pc=%h", j, bus.id_valid, bus.id_pc_next, 32'h41 + j);
            end
            to_pos();
        end
    endtask

    task automatic test_stop_debug();
        int exp_pc;
        logic [31:0] last_addr;
        reset_dut(1'b1);
        exp_pc = 1;
        last_addr = '0;
        for (int c = 0; c < 5; c++) begin
            to_neg();
            if (bus.imem_en) last_addr = bus.imem_addr;
            if (bus.id_valid) begin
                n_cmp++; if (bus.id_pc_next !== 32'(exp_pc) || bus.id_instr !== exp_instr(32'(exp_pc - 1))) begin
                    n_bad++; $display("FAIL stop_pre got pc=%h ins=%h want pc=%h", bus.id_pc_next, bus.id_instr, exp_pc);
                end
                exp_pc++;
            end
            to_pos();
        end
        stop_debug = 1'b1;
        for (int c = 0; c < 5; c++) begin
            to_neg();
            n_cmp++; if (bus.id_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
                n_bad++; $display("FAIL stop_frozen c=%0d got v=%b en=%b want 0 0", c, bus.id_valid, bus.imem_en);
            end
            to_pos();
        end
        stop_debug = 1'b0;
        for (int c = 0; c < 8; c++) begin
            to_neg();
            if (c == 0) begin
                n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== last_addr + 32'd1) begin
                    n_bad++; $display("FAIL stop_resume_addr got en=%b addr=%h want en=1 addr=%h", bus.imem_en, bus.imem_addr, last_addr + 32'd1);
                end
            end
            n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== 32'(exp_pc) || bus.id_instr !== exp_instr(32'(exp_pc - 1))) begin
                n_bad++; $display("FAIL stop_post c=%0d got v=%b pc=%h want v=1 pc=%h", c, bus.id_valid, bus.id_pc_next, exp_pc);
            end
            if (bus.id_valid) exp_pc++;
            to_pos();
        end
        n_cmp++; if (exp_pc !== 1 + (5 - LAT) + 8) begin
            n_bad++; $display("FAIL stop_word_count got %0d want %0d", exp_pc - 1, (5 - LAT) + 8);
        end
    endtask

    task automatic test_latency_wrap();
        bit got;
        reset_dut(1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        to_neg();
        n_cmp++; if (bus.imem_addr !== 32'h80 || bus.id_valid !== 1'b0) begin
            n_bad++; $display("FAIL lat_redirect got addr=%h v=%b want 80 0", bus.imem_addr, bus.id_valid);
        end
        to_pos();
        redirect_valid = 1'b0;
        to_neg();
        n_cmp++; if (bus.id_valid !== (LAT == 1)) begin
            n_bad++; $display("FAIL lat_t1 got v=%b want %b", bus.id_valid, LAT == 1);
        end
        to_pos();
        to_neg();
        n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== ((LAT == 1) ? 32'h82 : 32'h81)) begin
            n_bad++; $display("FAIL lat_t2 got v=%b pc=%h want v=1 pc=%h", bus.id_valid, bus.id_pc_next, (LAT == 1) ? 32'h82 : 32'h81);
        end
        to_pos();

        reset_dut(1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        to_neg();
        to_pos();
        redirect_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            to_neg();
            if (bus.id_valid) got = 1; else to_pos();
        end
        n_cmp++; if (!got || bus.id_pc_next !== 32'h0 || bus.id_instr !== exp_instr(32'hFFFF_FFFF)) begin
            n_bad++; $display("FAIL wrap_first got seen=%b pc=%h ins=%h want pc=0 ins=%h", got, bus.id_pc_next, bus.id_instr, exp_instr(32'hFFFF_FFFF));
        end
        to_pos();
        to_neg();
        n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc_next !== 32'h1 || bus.id_instr !== exp_instr(32'h0)) begin
            n_bad++; $display("FAIL wrap_second got v=%b pc=%h ins=%h want v=1 pc=1 ins=%h", bus.id_valid, bus.id_pc_next, bus.id_instr, exp_instr(32'h0));
        end
        to_pos();
    endtask

    task automatic test_load_program();
        bit got;
        reset_dut(1'b0);
        repeat (3) begin to_neg(); to_pos(); end
        load_program = 1'b1; load_we = 1'b1; load_addr = 32'h0; load_data = 32'hDEAD_BEEF;
        to_neg();
        n_cmp++; if (bus.imem_we !== 1'b1 || bus.imem_en !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_wdata !== 32'hDEAD_BEEF || bus.id_valid !== 1'b0) begin
            n_bad++; $display("FAIL load_w0 got we=%b en=%b addr=%h wd=%h v=%b", bus.imem_we, bus.imem_en, bus.imem_addr, bus.imem_wdata, bus.id_valid);
        end
        to_pos();
        load_addr = 32'h1; load_data = 32'h1234_5678;
        to_neg();
        n_cmp++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'h1) begin
            n_bad++; $display("FAIL load_w1 got we=%b addr=%h want 1 1", bus.imem_we, bus.imem_addr);
        end
        to_pos();
        load_we = 1'b0;
        to_neg();
        n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL load_idle_we got %b want 0", bus.imem_we); end
        to_pos();
        load_program = 1'b0; bus.id_ready = 1'b1;
        to_neg();
        n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL load_resume got en=%b addr=%h want 1 0", bus.imem_en, bus.imem_addr);
        end
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (k > 0) to_neg();
            if (bus.id_valid) got = 1; else to_pos();
        end
        n_cmp++; if (!got || bus.id_instr !== 32'hDEAD_BEEF || bus.id_pc_next !== 32'h1) begin
            n_bad++; $display("FAIL load_first got seen=%b ins=%h pc=%h want DEADBEEF 1", got, bus.id_instr, bus.id_pc_next);
        end
        to_pos();
        to_neg();
        n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h1234_5678 || bus.id_pc_next !== 32'h2) begin
            n_bad++; $display("FAIL load_second got v=%b ins=%h pc=%h want 1 12345678 2", bus.id_valid, bus.id_instr, bus.id_pc_next);
        end
        to_pos();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.imem_rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stop_debug();
        test_latency_wrap();
        test_load_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
